// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer and the downstream detector benches:
// FSM encoding, default width, count-width helper and transmit-order constants.
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam bit TX_MSB_FIRST = 1'b1;
    localparam bit TX_LSB_FIRST = 1'b0;

    // Bit index counter width; never below one bit so the counter always exists.
    function automatic int unsigned count_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / bit-out bus of the serializer: upstream handshake plus stall, serial stream out.
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             stall;
    logic             w;
    logic             w_valid;
    logic             last;

    modport master (
        output din, din_valid, stall,
        input  din_ready, w, w_valid, last
    );

    modport slave (
        input  din, din_valid, stall,
        output din_ready, w, w_valid, last
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts WIDTH-bit words on a valid/ready handshake and
// emits one registered bit per clock with valid and last-bit markers, no bubble between words.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = TX_MSB_FIRST
) (
    input  logic            clk,
    input  logic            reset,
    word_serializer_if.slave bus
);
    localparam int unsigned     CW       = count_width(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PRE_LAST = CW'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    count;
    logic             w_q;
    logic             w_valid_q;
    logic             last_q;

    logic             ready;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    always_comb begin
        ready     = ~bus.stall & ((state == IDLE) | last_q);
        accept    = bus.din_valid & ready;
        first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
        // sr still holds the unshifted word when the first bit goes out, so the
        // next bit sits one position in from the transmit end.
        next_bit  = MSB_FIRST ? sr[WIDTH-2] : sr[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            count     <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            last_q    <= 1'b0;
        end else if (!bus.stall) begin
            if (accept) begin
                state     <= SHIFT;
                sr        <= bus.din;
                count     <= '0;
                w_q       <= first_bit;
                w_valid_q <= 1'b1;
                last_q    <= 1'b0;
            end else if (state == SHIFT) begin
                if (count == LAST_CNT) begin
                    state     <= IDLE;
                    w_valid_q <= 1'b0;
                    last_q    <= 1'b0;
                end else begin
                    // Rotate rather than shift so every register bit stays in use.
                    sr        <= MSB_FIRST ? {sr[WIDTH-2:0], sr[WIDTH-1]}
                                           : {sr[0], sr[WIDTH-1:1]};
                    count     <= count + 1'b1;
                    w_q       <= next_bit;
                    last_q    <= (count == PRE_LAST);
                end
            end
        end
    end

    assign bus.din_ready = ready;
    assign bus.w         = w_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.last      = last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers driven in parallel and compared
// each cycle against a queue-based bit-stream model, plus directed word/stream checks.
module tb_word_serializer;
    import word_serializer_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         stall;

    int tests = 0;
    int fails = 0;

    word_serializer_if #(.WIDTH(W)) bm ();
    word_serializer_if #(.WIDTH(W)) bl ();

    assign bm.din = din;  assign bm.din_valid = din_valid;  assign bm.stall = stall;
    assign bl.din = din;  assign bl.din_valid = din_valid;  assign bl.stall = stall;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm));
    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl));

    always #5 clk = ~clk;

    // Model: current bit on w plus a queue of the bits still to come (index 0 = MSB-first DUT).
    bit mv [2];
    bit mc [2];
    bit q0 [$];
    bit q1 [$];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // {w, w_valid, last, din_ready}
    function automatic logic [3:0] model_out(input int i);
        bit lastb = mv[i] && (qsize(i) == 0);
        bit rdy   = !stall && (!mv[i] || qsize(i) == 0);
        return {mc[i], mv[i], lastb, rdy};
    endfunction

    function automatic logic [3:0] observed(input int i);
        return (i == 0) ? {bm.w, bm.w_valid, bm.last, bm.din_ready}
                        : {bl.w, bl.w_valid, bl.last, bl.din_ready};
    endfunction

    task automatic model_reset();
        mv = '{1'b0, 1'b0};
        mc = '{1'b0, 1'b0};
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit rdy = model_out(i)[0];
            if (stall) continue;
            if (din_valid && rdy) begin
                for (int b = 0; b < W; b++) begin
                    bit val = (i == 0) ? din[W-1-b] : din[b];
                    if (b == 0) mc[i] = val;
                    else if (i == 0) q0.push_back(val);
                    else q1.push_back(val);
                end
                mv[i] = 1'b1;
            end else if (mv[i]) begin
                if (qsize(i) == 0) mv[i] = 1'b0;
                else mc[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
            end
        end
    endtask

    task automatic drive(input bit s, input bit v, input logic [W-1:0] d);
        @(negedge clk);
        stall = s; din_valid = v; din = d;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (observed(i) !== 4'b0001) begin
                fails++;
                $display("FAIL reset dut%0d {w,w_valid,last,din_ready}=%b expected 0001", i, observed(i));
            end
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        logic [W-1:0] got0 = '0, got1 = '0;
        int nv = 0, lastpos = -1, nlast = 0;
        drive(0, 1, 8'hA5);
        advance();
        for (int c = 0; c < 11; c++) begin
            drive(0, 0, W'($urandom));
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (observed(i) !== model_out(i)) begin
                    fails++;
                    $display("FAIL single c%0d dut%0d {w,w_valid,last,din_ready}=%b expected %b", c, i, observed(i), model_out(i));
                end
            end
            if (bm.w_valid) begin
                got0 = {got0[W-2:0], bm.w};
                if (nv < W) got1[nv] = bl.w;
                nv++;
            end
            if (bm.last) begin lastpos = c; nlast++; end
            advance();
        end
        tests++;
        if (got0 !== 8'hA5 || got1 !== 8'hA5 || nv != 8) begin
            fails++;
            $display("FAIL single_stream msb=%h lsb=%h valid_cycles=%0d expected a5 a5 8", got0, got1, nv);
        end
        tests++;
        if (nlast != 1 || lastpos != 7 || bm.w !== 1'b1) begin
            fails++;
            $display("FAIL single_last count=%0d pos=%0d idle_w=%b expected 1 7 1", nlast, lastpos, bm.w);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2] = '{8'hA5, 8'h3C};
        logic [15:0]  stream = '0;
        int wi = 0, run = 0, maxrun = 0;
        for (int c = 0; c < 22; c++) begin
            bit v = (wi < 2);
            bit acc;
            drive(0, v, v ? words[wi] : W'($urandom));
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (observed(i) !== model_out(i)) begin
                    fails++;
                    $display("FAIL b2b c%0d dut%0d {w,w_valid,last,din_ready}=%b expected %b", c, i, observed(i), model_out(i));
                end
            end
            if (bm.w_valid) begin
                stream = {stream[14:0], bm.w};
                run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
            acc = v && model_out(0)[0];
            advance();
            if (acc) wi++;
        end
        tests++;
        if (stream !== 16'hA53C || maxrun != 16) begin
            fails++;
            $display("FAIL b2b_stream stream=%h run=%0d expected a53c 16", stream, maxrun);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] got = '0;
        int nv = 0;
        drive(0, 1, 8'hF0);
        advance();
        for (int c = 0; c < 14; c++) begin
            bit s = (c >= 3 && c <= 5);
            drive(s, 0, W'($urandom));
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (observed(i) !== model_out(i)) begin
                    fails++;
                    $display("FAIL stall c%0d dut%0d {w,w_valid,last,din_ready}=%b expected %b", c, i, observed(i), model_out(i));
                end
            end
            if (bm.w_valid) begin
                nv++;
                if (!s) got = {got[W-2:0], bm.w};
            end
            advance();
        end
        tests++;
        if (got !== 8'hF0 || nv != 11) begin
            fails++;
            $display("FAIL stall_stream word=%h valid_cycles=%0d expected f0 11", got, nv);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] first = W'($urandom);
        logic [15:0]  stream = '0;
        bit held = 1'b0;
        drive(0, 1, first);
        advance();
        for (int c = 0; c < 20; c++) begin
            bit v = (c >= 2) && !held;
            bit acc;
            drive(0, v, v ? 8'h55 : W'($urandom));
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (observed(i) !== model_out(i)) begin
                    fails++;
                    $display("FAIL hold c%0d dut%0d {w,w_valid,last,din_ready}=%b expected %b", c, i, observed(i), model_out(i));
                end
            end
            if (bm.w_valid) stream = {stream[14:0], bm.w};
            acc = v && model_out(0)[0];
            advance();
            if (acc) held = 1'b1;
        end
        tests++;
        if (stream !== {first, 8'h55}) begin
            fails++;
            $display("FAIL hold_stream stream=%h expected %h", stream, {first, 8'h55});
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] got = '0;
        drive(0, 1, W'($urandom));
        advance();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, W'($urandom));
            if (c < 4) advance();
        end
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (observed(i) !== 4'b0001) begin
                fails++;
                $display("FAIL async_reset dut%0d {w,w_valid,last,din_ready}=%b expected 0001", i, observed(i));
            end
        end
        reset = 1'b1;
        model_reset();
        advance();
        drive(0, 1, 8'h81);
        advance();
        for (int c = 0; c < 9; c++) begin
            drive(0, 0, W'($urandom));
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (observed(i) !== model_out(i)) begin
                    fails++;
                    $display("FAIL post_reset c%0d dut%0d {w,w_valid,last,din_ready}=%b expected %b", c, i, observed(i), model_out(i));
                end
            end
            if (bm.w_valid) got = {got[W-2:0], bm.w};
            advance();
        end
        tests++;
        if (got !== 8'h81) begin
            fails++;
            $display("FAIL post_reset_stream word=%h expected 81", got);
        end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] seq = '0;
        logic         last_w = 1'b1, last_seen = 1'b0;
        drive(0, 1, 8'h01);
        advance();
        for (int c = 0; c < W; c++) begin
            drive(0, 0, W'($urandom));
            seq[W-1-c] = bl.w;
            if (c == W - 1) begin last_seen = bl.last; last_w = bl.w; end
            advance();
        end
        tests++;
        if (seq !== 8'b1000_0000 || last_seen !== 1'b1 || last_w !== 1'b0) begin
            fails++;
            $display("FAIL lsb_first seq=%b last=%b w_at_last=%b expected 10000000 1 0", seq, last_seen, last_w);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] cur = '0;
        bit v = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bit s = ($urandom_range(0, 4) == 0);
            bit acc;
            if (!v) begin
                v   = ($urandom_range(0, 2) != 0);
                cur = W'($urandom);
            end
            drive(s, v, cur);
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (observed(i) !== model_out(i)) begin
                    fails++;
                    $display("FAIL random c%0d dut%0d {w,w_valid,last,din_ready}=%b expected %b", c, i, observed(i), model_out(i));
                end
            end
            acc = v && model_out(0)[0];
            advance();
            if (acc) v = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_hold();
        test_async_reset();
        test_lsb_first();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parallel-to-serial front end for the single-bit sequence-detector stages. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on w, with a w_valid qualifier. It supports back-to-back words with no idle bubble, an upstream-controlled stall, and a last-bit marker, so the downstream detector always sees a continuous, well-defined bit stream.

Parameters:
WIDTH, 8, word length in bits (legal range 2..32)
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a word to transfer
din_ready  output  1  block can accept din at the next rising edge
stall  input  1  freeze the shift: hold w, count, and state
w  output  1  current serial bit (registered)
w_valid  output  1  w carries a bit of a word (registered)
last  output  1  w carries the final bit of the current word (registered)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0, every register is forced to its reset value immediately, independent of clk.
- Reset values: state=IDLE, shift register=0, count=0, w=0, w_valid=0, last=0. din_ready=1 because it is decoded from IDLE.
- States:
  - IDLE: no word in flight.
  - SHIFT: a word is being emitted.
- Accept condition: din_valid & din_ready & ~stall at a rising edge. This loads the shift register with din and clears count to 0.
- din_ready (combinational from registers):
  - 1 in IDLE.
  - 1 in SHIFT when last=1.
  - 0 in all other cases.
  - It does not depend on din_valid.
  - It is forced to 0 while stall=1.
- Latency: a word accepted at edge k presents its first bit on w in the cycle after edge k. Bit i of the transmit order appears in cycle k+1+i. last=1 in cycle k+WIDTH.
- In SHIFT with stall=0, each edge advances one bit: the shift register shifts and count increments.
- When count reaches WIDTH-1, w carries the final bit and last=1. At the next edge:
  - if a word is accepted, the block reloads and stays in SHIFT. w_valid stays 1 and the new word's first bit follows immediately, with no bubble.
  - otherwise the block goes to IDLE and w_valid drops to 0.
- In IDLE, w holds the last transmitted bit (or 0 after reset). It must not toggle spuriously.
- stall=1 freezes state, count, shift register, w, w_valid, and last. No accept happens while stalled. stall in IDLE has no other effect.
- If din_valid is asserted while din_ready=0, nothing happens. Upstream must hold din and din_valid until acceptance. din is sampled only on accept.
- count width is $clog2(WIDTH). There is no wrap past WIDTH-1: count is reloaded or the block leaves SHIFT.
- Reset mid-word: the in-flight word is discarded and outputs return to reset values at once. After reset releases, the next accept starts a fresh word from bit 0.
- w, w_valid, and last are glitch-free register outputs. The downstream Mealy stage samples w on the same clk.

Decomposition:
- Shared package:
  - state encoding (IDLE=1'b0, SHIFT=1'b1)
  - default WIDTH
  - the count-width function (clog2)
  - the transmit-order select constants, reused by the downstream detector benches
- No sub-module. The shift register, counter, and two-state FSM form a single module.

Test Plan:
- Single word: reset, then one accept of din=8'hA5 (MSB_FIRST=1) -> w = 1,0,1,0,0,1,0,1 in cycles 1..8. w_valid=1 for exactly 8 cycles. last=1 only in cycle 8. Then IDLE with w held at 1.
- Back-to-back: 8'hA5 accepted, then 8'h3C presented with din_valid held -> 8'h3C accepted at the edge ending cycle 8. w_valid stays high for 16 consecutive cycles. Stream is 10100101 00111100.
- Stall: stall=1 for 3 cycles while bit 3 of 8'hF0 is on w -> w, last, and count frozen for 3 cycles. The remaining bits resume unchanged. Total w_valid high time is 11 cycles.
- Handshake hold: din_valid=1 with din=8'h55 while mid-word (count=2) -> din_ready=0 and no load. The word is accepted only when last=1, and 8'h55 is then emitted intact.
- Async reset mid-word: reset=0 between clock edges at count=4 -> w, w_valid, and last go to 0 immediately. After release, accepting 8'h81 emits 1,0,0,0,0,0,0,1.
- LSB_FIRST: MSB_FIRST=0, din=8'h01 -> w = 1,0,0,0,0,0,0,0. last=1 with w=0 in cycle 8.
